// File: rtl/sram_arb_pkg.sv
// Shared definitions for the sram-like bus arbiter: owner tags, transfer size
// encodings and the request bundle that is muxed onto the shared bus.
package sram_arb_pkg;

  // Owner tag stored per accepted transaction
  localparam logic TAG_INST = 1'b0;
  localparam logic TAG_DATA = 1'b1;

  // Transfer size encodings on the sram-like interface
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Everything that travels with an address phase besides req itself
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/resp_tag_fifo.sv
// In-order owner-tag FIFO for the sram bus arbiter. One bit per entry,
// DEPTH entries, registered full/empty, wrapping pointers and a concurrent
// push+pop that leaves the occupancy unchanged.
module resp_tag_fifo
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             tag_i,
  input  logic             pop_i,
  output logic             head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             doPush, doPop;

  assign doPush = push_i & ~full_q;
  assign doPop  = pop_i & ~empty_q;

  // Next pointers wrap at DEPTH-1; occupancy only moves on an unpaired push or pop
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = (wrPtr_q == PTR_W'(DEPTH - 1)) ? '0 : wrPtr_q + PTR_W'(1);
    if (doPop)  rdPtr_d = (rdPtr_q == PTR_W'(DEPTH - 1)) ? '0 : rdPtr_q + PTR_W'(1);
    if (doPush && !doPop)      count_d = count_q + CNT_W'(1);
    else if (!doPush && doPop) count_d = count_q - CNT_W'(1);
  end

  // Pointer, count and registered full/empty flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Tag storage; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= tag_i;
  end

  assign head_o  = mem_q[rdPtr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one sram-like port between instruction fetch and the data side.
// Same-cycle grant with a handshake lock, in-order owner tags for response
// routing. Optional round-robin between simultaneous requesters when
// SRAM_ARB_RR_EN is defined; otherwise the data side has fixed priority.
module sram_bus_arbiter
  import sram_arb_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  localparam int CNT_W = $clog2(OUTSTANDING + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata,
  output logic        busy
);

  logic             grant;
  logic             lock_q, lock_d;
  logic             lockOwner_q, lockOwner_d;
  logic             ownerReq, lockActive;
  logic             full, empty, headTag;
  logic [CNT_W-1:0] count;
  logic             push, pop;
  bus_req_t         instBus, dataBus, grantBus;

  assign instBus = '{wr: inst_wr, size: inst_size, addr: inst_addr, wstrb: inst_wstrb, wdata: inst_wdata};
  assign dataBus = '{wr: data_wr, size: data_size, addr: data_addr, wstrb: data_wstrb, wdata: data_wdata};

  // A pending handshake only pins the grant while its owner keeps requesting
  assign ownerReq   = (lockOwner_q == TAG_DATA) ? data_req : inst_req;
  assign lockActive = lock_q & ownerReq;

`ifdef SRAM_ARB_RR_EN
  logic lastGrant_q;

  // Last side that won an address phase, used to alternate on contention
  always_ff @(posedge clk) begin
    if (reset)     lastGrant_q <= TAG_INST;
    else if (push) lastGrant_q <= grant;
  end
`endif

  // Same-cycle grant: lock first, then contention policy, then whoever asks
  always_comb begin
    grant = TAG_INST;
    if (lockActive) begin
      grant = lockOwner_q;
`ifdef SRAM_ARB_RR_EN
    end else if (inst_req && data_req) begin
      grant = ~lastGrant_q;
`endif
    end else if (data_req) begin
      grant = TAG_DATA;
    end
  end

  assign grantBus = (grant == TAG_DATA) ? dataBus : instBus;
  assign req      = ~reset & ~full & ((grant == TAG_DATA) ? data_req : inst_req);
  assign wr       = grantBus.wr;
  assign size     = grantBus.size;
  assign addr     = grantBus.addr;
  assign wstrb    = grantBus.wstrb;
  assign wdata    = grantBus.wdata;

  assign inst_addr_ok = addr_ok & req & (grant == TAG_INST);
  assign data_addr_ok = addr_ok & req & (grant == TAG_DATA);

  // Responses with nothing outstanding, or during reset, are dropped
  assign push = req & addr_ok;
  assign pop  = data_ok & ~empty & ~reset;

  assign inst_data_ok = pop & (headTag == TAG_INST);
  assign data_data_ok = pop & (headTag == TAG_DATA);
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;
  assign busy         = ~reset & (count != '0);

  // Hold the grant while an address phase waits for addr_ok
  always_comb begin
    lock_d      = 1'b0;
    lockOwner_d = lockOwner_q;
    if (req && !addr_ok) begin
      lock_d      = 1'b1;
      lockOwner_d = grant;
    end
  end

  // Lock state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q      <= 1'b0;
      lockOwner_q <= TAG_INST;
    end else begin
      lock_q      <= lock_d;
      lockOwner_q <= lockOwner_d;
    end
  end

  resp_tag_fifo #(.DEPTH(OUTSTANDING)) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .tag_i   (grant),
    .pop_i   (pop),
    .head_o  (headTag),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter. Expected owners are queued when an
// address phase is expected to be accepted and popped when a response is driven.
module tb_sram_bus_arbiter;
  import sram_arb_pkg::*;

  localparam int OUTSTANDING = 2;
  localparam logic [31:0] INST_ADDR  = 32'h1FC0_0100;
  localparam logic [31:0] DATA_ADDR  = 32'h8000_0040;
  localparam logic [31:0] DATA_WDATA = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic [3:0]  inst_wstrb;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        req, wr, addr_ok, data_ok, busy;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wstrb;

  int   testsRun = 0;
  int   testsFailed = 0;
  logic expOwner[$];
  logic modelLast;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .req(req), .wr(wr), .size(size), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .busy(busy)
  );

  // Drives the per-cycle handshake inputs and lets combinational outputs settle
  task automatic applyStimulus(input logic ir, input logic dr, input logic aok,
                               input logic dok, input logic [31:0] rd);
    inst_req = ir;
    data_req = dr;
    addr_ok  = aok;
    data_ok  = dok;
    rdata    = rd;
    #2;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference grant for an unlocked cycle
  function automatic logic expectGrant(input logic ir, input logic dr);
`ifdef SRAM_ARB_RR_EN
    if (ir && dr) return ~modelLast;
`endif
    if (ir && !dr) return TAG_INST;
    return dr ? TAG_DATA : TAG_INST;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1, 1, 1, 1, 32'h5555_5555);
    testsRun++;
    if ({req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy} !== 6'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs_pre_edge: got %b, expected 000000",
               {req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy});
    end
    nextCycle();
    #2;
    testsRun++;
    if ({req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy} !== 6'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs_held: got %b, expected 000000",
               {req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy});
    end
    nextCycle();
    reset = 1'b0;
    modelLast = TAG_INST;
    expOwner.delete();
    applyStimulus(0, 0, 0, 0, 32'h0);
    testsRun++;
    if ({req, busy} !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL reset_idle: got req,busy=%b, expected 00", {req, busy});
    end
  endtask

  task automatic test_fill();
    logic g, o;
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1, 1, 1, 0, 32'h0);
      g = expectGrant(1, 1);
      testsRun++;
      if ({inst_addr_ok, data_addr_ok} !== {g == TAG_INST, g == TAG_DATA}) begin
        testsFailed++;
        $display("[TB] FAIL fill_grant_%0d: got inst/data addr_ok=%b, expected %b", c,
                 {inst_addr_ok, data_addr_ok}, {g == TAG_INST, g == TAG_DATA});
      end
      testsRun++;
      if (addr !== ((g == TAG_DATA) ? DATA_ADDR : INST_ADDR)) begin
        testsFailed++;
        $display("[TB] FAIL fill_addr_%0d: got %h, expected %h", c, addr,
                 (g == TAG_DATA) ? DATA_ADDR : INST_ADDR);
      end
      expOwner.push_back(g);
      modelLast = g;
      nextCycle();
    end
    applyStimulus(1, 1, 1, 0, 32'h0);
    testsRun++;
    if ({req, inst_addr_ok, data_addr_ok, busy} !== 4'b0001) begin
      testsFailed++;
      $display("[TB] FAIL fill_full: got req,iaok,daok,busy=%b, expected 0001",
               {req, inst_addr_ok, data_addr_ok, busy});
    end
    nextCycle();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 0, 0, 1, 32'hC0DE_0000 + k);
      o = expOwner.pop_front();
      testsRun++;
      if ({inst_data_ok, data_data_ok, data_rdata} !== {o == TAG_INST, o == TAG_DATA, 32'hC0DE_0000 + k}) begin
        testsFailed++;
        $display("[TB] FAIL fill_drain_%0d: got iok,dok=%b rdata=%h, expected %b rdata=%h", k,
                 {inst_data_ok, data_data_ok}, data_rdata, {o == TAG_INST, o == TAG_DATA},
                 32'hC0DE_0000 + k);
      end
      nextCycle();
    end
    applyStimulus(0, 0, 0, 0, 32'h0);
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL fill_idle_busy: got %b, expected 0", busy);
    end
  endtask

  task automatic test_order();
    logic [31:0] vals [2];
    logic o;
    vals[0] = 32'h1111_1111;
    vals[1] = 32'h2222_2222;
    applyStimulus(1, 0, 1, 0, 32'h0);
    testsRun++;
    if ({inst_addr_ok, data_addr_ok, addr, wr, size, wstrb, wdata} !==
        {2'b10, INST_ADDR, 1'b0, SIZE_WORD, 4'hF, 32'h0}) begin
      testsFailed++;
      $display("[TB] FAIL order_inst_phase: got aok=%b addr=%h wr=%b size=%0d wstrb=%h wdata=%h, expected 10 %h 0 2 f 0",
               {inst_addr_ok, data_addr_ok}, addr, wr, size, wstrb, wdata, INST_ADDR);
    end
    expOwner.push_back(TAG_INST);
    modelLast = TAG_INST;
    nextCycle();
    applyStimulus(0, 1, 1, 0, 32'h0);
    testsRun++;
    if ({inst_addr_ok, data_addr_ok, addr, wr, size, wstrb, wdata} !==
        {2'b01, DATA_ADDR, 1'b1, SIZE_BYTE, 4'h1, DATA_WDATA}) begin
      testsFailed++;
      $display("[TB] FAIL order_data_phase: got aok=%b addr=%h wr=%b size=%0d wstrb=%h wdata=%h, expected 01 %h 1 0 1 %h",
               {inst_addr_ok, data_addr_ok}, addr, wr, size, wstrb, wdata, DATA_ADDR, DATA_WDATA);
    end
    expOwner.push_back(TAG_DATA);
    modelLast = TAG_DATA;
    nextCycle();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 0, 0, 1, vals[k]);
      o = expOwner.pop_front();
      testsRun++;
      if ({inst_data_ok, data_data_ok, inst_rdata, data_rdata} !==
          {o == TAG_INST, o == TAG_DATA, vals[k], vals[k]}) begin
        testsFailed++;
        $display("[TB] FAIL order_resp_%0d: got iok,dok=%b irdata=%h drdata=%h, expected %b %h", k,
                 {inst_data_ok, data_data_ok}, inst_rdata, data_rdata,
                 {o == TAG_INST, o == TAG_DATA}, vals[k]);
      end
      nextCycle();
    end
  endtask

  task automatic test_lock();
    logic o;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, (c != 0), 0, 0, 32'h0);
      testsRun++;
      if ({req, inst_addr_ok, data_addr_ok, addr} !== {3'b100, INST_ADDR}) begin
        testsFailed++;
        $display("[TB] FAIL lock_hold_%0d: got req,iaok,daok=%b addr=%h, expected 100 %h", c,
                 {req, inst_addr_ok, data_addr_ok}, addr, INST_ADDR);
      end
      nextCycle();
    end
    applyStimulus(1, 1, 1, 0, 32'h0);
    testsRun++;
    if ({inst_addr_ok, data_addr_ok, addr} !== {2'b10, INST_ADDR}) begin
      testsFailed++;
      $display("[TB] FAIL lock_accept_inst: got aok=%b addr=%h, expected 10 %h",
               {inst_addr_ok, data_addr_ok}, addr, INST_ADDR);
    end
    expOwner.push_back(TAG_INST);
    modelLast = TAG_INST;
    nextCycle();
    applyStimulus(0, 1, 1, 0, 32'h0);
    testsRun++;
    if ({inst_addr_ok, data_addr_ok, addr} !== {2'b01, DATA_ADDR}) begin
      testsFailed++;
      $display("[TB] FAIL lock_then_data: got aok=%b addr=%h, expected 01 %h",
               {inst_addr_ok, data_addr_ok}, addr, DATA_ADDR);
    end
    expOwner.push_back(TAG_DATA);
    modelLast = TAG_DATA;
    nextCycle();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 0, 0, 1, 32'h3300_0000 + k);
      o = expOwner.pop_front();
      testsRun++;
      if ({inst_data_ok, data_data_ok} !== {o == TAG_INST, o == TAG_DATA}) begin
        testsFailed++;
        $display("[TB] FAIL lock_resp_%0d: got iok,dok=%b, expected %b", k,
                 {inst_data_ok, data_data_ok}, {o == TAG_INST, o == TAG_DATA});
      end
      nextCycle();
    end
  endtask

  task automatic test_full_refill();
    logic o;
    for (int c = 0; c < 2; c++) begin
      applyStimulus(0, 1, 1, 0, 32'h0);
      testsRun++;
      if (data_addr_ok !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL refill_prefill_%0d: got data_addr_ok=%b, expected 1", c, data_addr_ok);
      end
      expOwner.push_back(TAG_DATA);
      nextCycle();
    end
    applyStimulus(0, 1, 1, 1, 32'h5A5A_5A5A);
    o = expOwner.pop_front();
    testsRun++;
    if ({req, data_addr_ok, inst_data_ok, data_data_ok, busy, data_rdata} !==
        {1'b0, 1'b0, o == TAG_INST, o == TAG_DATA, 1'b1, 32'h5A5A_5A5A}) begin
      testsFailed++;
      $display("[TB] FAIL refill_pop_while_full: got req,daok,iok,dok,busy=%b rdata=%h, expected 00%b1 5a5a5a5a",
               {req, data_addr_ok, inst_data_ok, data_data_ok, busy}, data_rdata,
               {o == TAG_INST, o == TAG_DATA});
    end
    nextCycle();
    applyStimulus(0, 1, 1, 0, 32'h0);
    testsRun++;
    if ({req, data_addr_ok} !== 2'b11) begin
      testsFailed++;
      $display("[TB] FAIL refill_accept: got req,daok=%b, expected 11", {req, data_addr_ok});
    end
    expOwner.push_back(TAG_DATA);
    modelLast = TAG_DATA;
    nextCycle();
    applyStimulus(0, 1, 1, 0, 32'h0);
    testsRun++;
    if ({req, data_addr_ok, busy} !== 3'b001) begin
      testsFailed++;
      $display("[TB] FAIL refill_full_again: got req,daok,busy=%b, expected 001",
               {req, data_addr_ok, busy});
    end
    nextCycle();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 0, 0, 1, 32'h4400_0000 + k);
      o = expOwner.pop_front();
      testsRun++;
      if ({inst_data_ok, data_data_ok} !== {o == TAG_INST, o == TAG_DATA}) begin
        testsFailed++;
        $display("[TB] FAIL refill_drain_%0d: got iok,dok=%b, expected %b", k,
                 {inst_data_ok, data_data_ok}, {o == TAG_INST, o == TAG_DATA});
      end
      nextCycle();
    end
  endtask

  task automatic test_spurious();
    applyStimulus(0, 0, 0, 1, 32'h0BAD_0001);
    testsRun++;
    if ({inst_data_ok, data_data_ok, busy} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL spurious_empty: got iok,dok,busy=%b, expected 000",
               {inst_data_ok, data_data_ok, busy});
    end
    nextCycle();
    applyStimulus(1, 0, 1, 0, 32'h0);
    testsRun++;
    if ({busy, inst_addr_ok} !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL spurious_no_state_change: got busy,iaok=%b, expected 01", {busy, inst_addr_ok});
    end
    modelLast = TAG_INST;
    nextCycle();
    applyStimulus(0, 0, 0, 0, 32'h0);
    testsRun++;
    if (busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL spurious_one_outstanding: got busy=%b, expected 1", busy);
    end
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    expOwner.delete();
    modelLast = TAG_INST;
    applyStimulus(0, 0, 0, 1, 32'h0BAD_0002);
    testsRun++;
    if ({inst_data_ok, data_data_ok, busy} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL spurious_after_reset: got iok,dok,busy=%b, expected 000",
               {inst_data_ok, data_data_ok, busy});
    end
    nextCycle();
    applyStimulus(0, 0, 0, 0, 32'h0);
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL spurious_busy_stays_low: got %b, expected 0", busy);
    end
  endtask

  task automatic test_arbitration();
    logic g, o;
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 32'h0);
    nextCycle();
    reset = 1'b0;
    expOwner.delete();
    modelLast = TAG_INST;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1, 1, 1, 1, 32'hA000_0000 + c);
      g = expectGrant(1, 1);
      if (expOwner.size() == 0) begin
        testsRun++;
        if ({inst_data_ok, data_data_ok} !== 2'b00) begin
          testsFailed++;
          $display("[TB] FAIL arb_resp_%0d: got iok,dok=%b, expected 00", c, {inst_data_ok, data_data_ok});
        end
      end else begin
        o = expOwner.pop_front();
        testsRun++;
        if ({inst_data_ok, data_data_ok} !== {o == TAG_INST, o == TAG_DATA}) begin
          testsFailed++;
          $display("[TB] FAIL arb_resp_%0d: got iok,dok=%b, expected %b", c,
                   {inst_data_ok, data_data_ok}, {o == TAG_INST, o == TAG_DATA});
        end
      end
      testsRun++;
      if ({inst_addr_ok, data_addr_ok} !== {g == TAG_INST, g == TAG_DATA}) begin
        testsFailed++;
        $display("[TB] FAIL arb_grant_%0d: got iaok,daok=%b, expected %b", c,
                 {inst_addr_ok, data_addr_ok}, {g == TAG_INST, g == TAG_DATA});
      end
      expOwner.push_back(g);
      modelLast = g;
      nextCycle();
    end
    applyStimulus(0, 0, 0, 1, 32'hA000_00FF);
    o = expOwner.pop_front();
    testsRun++;
    if ({inst_data_ok, data_data_ok} !== {o == TAG_INST, o == TAG_DATA}) begin
      testsFailed++;
      $display("[TB] FAIL arb_last_resp: got iok,dok=%b, expected %b",
               {inst_data_ok, data_data_ok}, {o == TAG_INST, o == TAG_DATA});
    end
    nextCycle();
    applyStimulus(0, 0, 0, 0, 32'h0);
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL arb_idle_busy: got %b, expected 0", busy);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    inst_req   = 1'b0;
    inst_wr    = 1'b0;
    inst_size  = SIZE_WORD;
    inst_addr  = INST_ADDR;
    inst_wstrb = 4'hF;
    inst_wdata = 32'h0;
    data_req   = 1'b0;
    data_wr    = 1'b1;
    data_size  = SIZE_BYTE;
    data_addr  = DATA_ADDR;
    data_wstrb = 4'h1;
    data_wdata = DATA_WDATA;
    addr_ok    = 1'b0;
    data_ok    = 1'b0;
    rdata      = 32'h0;
    modelLast  = TAG_INST;
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_order();
    test_lock();
    test_full_refill();
    test_spurious();
    test_arbitration();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
Shares one sram-like memory port between the instruction-fetch requester (IF) and the data requester (EX issues, MEM consumes).
- Arbitrates each address phase.
- Records the owner of every accepted transaction in an in-order tag FIFO.
- Routes each data_ok/rdata response back to its owner.
- Sits between the pipeline front/back ends and the memory bridge; the MEM stage waits on data_data_ok before ready_go.

Parameters:
OUTSTANDING, 2, maximum accepted-but-unanswered transactions (legal 1..8)
CNT_W, $clog2(OUTSTANDING+1), width of occupancy counter (derived, not overridden)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
inst_req  in  1  IF request valid
inst_wr  in  1  IF write (always 0 in practice, still forwarded)
inst_size  in  2  0=byte 1=half 2=word
inst_addr  in  32  IF address
inst_wstrb  in  4  IF byte strobes
inst_wdata  in  32  IF write data
inst_addr_ok  out  1  IF address phase accepted
inst_data_ok  out  1  IF response returned
inst_rdata  out  32  IF read data
data_req  in  1  data request valid
data_wr  in  1  store
data_size  in  2  size
data_addr  in  32  data address
data_wstrb  in  4  byte strobes
data_wdata  in  32  store data
data_addr_ok  out  1  data address phase accepted
data_data_ok  out  1  data response returned
data_rdata  out  32  load data
req  out  1  bus request
wr  out  1  bus write
size  out  2  bus size
addr  out  32  bus address
wstrb  out  4  bus strobes
wdata  out  32  bus write data
addr_ok  in  1  bus accepted address phase
data_ok  in  1  bus response
rdata  in  32  bus read data
busy  out  1  at least one transaction outstanding

Behaviour:
- Reset: tag FIFO empty, count=0, lock=0, last_grant=INST.
  - While reset is high: req=0, inst/data_addr_ok=0, inst/data_data_ok=0, busy=0.
  - Reset mid-transaction drops all tags; responses arriving after reset are ignored.
- full = (count==OUTSTANDING), registered.
  - When full, req=0 and both addr_ok outputs are 0, even if a pop occurs in the same cycle.
- Grant is combinational, same cycle, zero latency:
  - If lock=1, the grant stays with lock_owner.
  - Otherwise data wins when data_req=1 (fixed priority); else inst.
- Bus outputs:
  - req = granted requester's req & ~full.
  - wr/size/addr/wstrb/wdata are muxed from the granted side.
- addr_ok routing: inst_addr_ok = addr_ok & req & grant==INST; data_addr_ok likewise for DATA.
- Lock:
  - Set when req=1 and addr_ok=0 (handshake pending); lock_owner = current grant.
  - Cleared on req & addr_ok, or when the owner drops its req.
  - Prevents switching owner mid-handshake.
- Push: on req & addr_ok, push the grant tag (0=INST, 1=DATA); count+1.
- Pop: on data_ok with count!=0, pop the head tag; count-1. The popped tag drives inst_data_ok or data_data_ok in the same cycle.
- Simultaneous push and pop: count unchanged; FIFO pointers both advance.
- Pop-then-refill on full: takes effect the next cycle.
- rdata is broadcast unmodified to inst_rdata and data_rdata; consumers qualify it with their data_ok.
- data_ok with count==0 is a protocol violation: ignored, no state change, no data_ok forwarded.
- Ordering: responses are strictly in acceptance order; the FIFO head always names the owner.
- busy = (count!=0).

Optional Feature:
SRAM_ARB_RR_EN
- Defined: when unlocked and both requesters assert req, grant goes to the side not equal to last_grant. last_grant updates on every push.
- Undefined: fixed data priority as above. last_grant register is not instantiated.

Decomposition:
- Package sram_arb_pkg holds:
  - TAG_INST=1'b0, TAG_DATA=1'b1
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings
  - typedef of the bus request bundle {wr,size,addr,wstrb,wdata}
- Sub-module resp_tag_fifo: 1-bit wide, depth OUTSTANDING.
  - Push/pop with registered full and empty.
  - Handles simultaneous push and pop, and pointer wrap-around.

Test Plan:
- Both req=1, addr_ok=1 every cycle, OUTSTANDING=2, no data_ok:
  - cycle0 data_addr_ok=1, cycle1 data_addr_ok=1, cycle2 req=0 (full), busy=1.
- inst accepted, then data accepted; bus data_ok with rdata=0x11111111, then 0x22222222:
  - inst_data_ok pulses first with 0x11111111, data_data_ok pulses next with 0x22222222.
- inst_req held, addr_ok=0 for 3 cycles; data_req rises in cycle1:
  - grant stays INST (lock), addr points to inst_addr until addr_ok, then data is granted.
- Full FIFO; data_ok and a new data_req in the same cycle:
  - response routed, no addr_ok that cycle; next cycle data_addr_ok=1, count back to 2.
- data_ok=1 with count=0:
  - no data_ok forwarded, busy stays 0.
  - reset asserted with 1 outstanding: busy=0 next cycle; the late data_ok is ignored.
- With SRAM_ARB_RR_EN, both req=1, addr_ok=1, data_ok each cycle:
  - grants alternate DATA, INST, DATA, INST.
